// File: rtl/md_unit.sv
// Multiply/divide unit holding the HI/LO pair. MTHI and MTLO complete at once.
// MULT, MULTU, DIV and DIVU run for a fixed number of cycles before HI/LO change.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] res_q;
  logic        write_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] res_d;
  logic        write_d;
  logic [4:0]  cnt_d;

  logic        negA;
  logic        negB;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] magQuot;
  logic [31:0] magRem;
  logic [31:0] sQuot;
  logic [31:0] sRem;

  // Signed division runs on magnitudes. The overflow case falls out naturally:
  // |0x80000000| / 1 gives 0x80000000, and negating it leaves it unchanged.
  assign negA    = a[31];
  assign negB    = b[31];
  assign absA    = negA ? -a : a;
  assign absB    = negB ? -b : b;
  assign magQuot = absA / absB;
  assign magRem  = absA % absB;
  assign sQuot   = (negA ^ negB) ? -magQuot : magQuot;
  assign sRem    = negA ? -magRem : magRem;

  always_comb begin
    res_d   = 64'd0;
    write_d = 1'b1;
    cnt_d   = 5'(MULT_CYCLES);
    case (op[1:0])
      2'd0: res_d = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'd1: res_d = {32'd0, a} * {32'd0, b};
      2'd2: begin
        res_d   = {sRem, sQuot};
        write_d = (b != 32'd0);
        cnt_d   = 5'(DIV_CYCLES);
      end
      default: begin
        res_d   = {a % b, a / b};
        write_d = (b != 32'd0);
        cnt_d   = 5'(DIV_CYCLES);
      end
    endcase
  end

  // The result is captured at issue so that later operand changes cannot affect it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      res_q   <= 64'd0;
      write_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              res_q   <= res_d;
              write_q <= write_d;
              cnt_q   <= cnt_d;
              state_q <= RUN;
            end else if (op == 3'd4) begin
              hi_q <= a;
            end else if (op == 3'd5) begin
              lo_q <= a;
            end
          end
        end
        default: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= IDLE;
            if (write_q) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
          end
        end
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == RUN);
  assign stall = busy | (start & ~op[2]);

endmodule
